param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 14, counter width in bits.
REQ-002 SHALL have parameter CMIN, default 0, lower count limit.
REQ-003 SHALL have parameter CMAX, default 100, upper count limit; legal range CMIN < CMAX <= 2^WIDTH-1.
REQ-004 SHALL have parameter STEP, default 1, increment/decrement per enabled cycle; legal range 1..(CMAX-CMIN).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-low (0 = reset).
REQ-007 SHALL have port en  input  1  count enable.
REQ-008 SHALL have port clr  input  1  synchronous clear to CMIN.
REQ-009 SHALL have port load  input  1  synchronous parallel load.
REQ-010 SHALL have port data_in  input  WIDTH  load value.
REQ-011 SHALL have port up_down  input  1  direction request: 1 = up, 0 = down.
REQ-012 SHALL have port mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 ping-pong.
REQ-013 SHALL have port count  output  WIDTH  registered count value.
REQ-014 SHALL have port dir  output  1  registered effective direction: 1 = up.
REQ-015 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-016 SHALL have port done  output  1  registered one-shot completion flag.

Function
REQ-017 SHALL apply per-edge priority: clr > load > en step > hold.
REQ-018 SHALL on clr set count=CMIN, done=0; in modes 00/01/10 dir follows up_down; in mode 11 dir=1.
REQ-019 SHALL on load set count=data_in clamped to [CMIN,CMAX] and done=0; dir handled as in clr.
REQ-020 SHALL outside mode 11 register dir=up_down every edge; in mode 11 ignore up_down.
REQ-021 SHALL compute steps in WIDTH+1 bits so no intermediate overflow or underflow is possible.
REQ-022 SHALL when stepping up with count+STEP > CMAX: mode 00 -> CMIN; modes 01/10/11 -> CMAX.
REQ-023 SHALL when stepping down with count < CMIN+STEP: mode 00 -> CMAX; modes 01/10/11 -> CMIN.
REQ-024 SHALL otherwise set count = count +/- STEP.
REQ-025 SHALL define a limit event as an enabled step that wraps (mode 00) or that moves count onto the limit of the current direction from a different value (modes 01/10/11).
REQ-026 SHALL assert tc for exactly the one cycle following each limit event; holding at a limit in mode 01 SHALL NOT re-pulse tc.
REQ-027 SHALL in mode 10 set done=1 on a limit event and then freeze count while done=1, regardless of en.
REQ-028 SHALL clear done only on clr, on load, or on the edge where mode != 10.
REQ-029 SHALL in mode 11 toggle dir on the same edge as a limit event, so the next step moves away from the limit.
REQ-030 SHALL apply a mode change on the edge where it is sampled, using the current count and dir.
REQ-031 SHALL hold count, dir and done with tc=0 when en=0 and neither clr nor load is active.

Reset
REQ-032 SHALL while rst=0 force count=CMIN, dir=1, tc=0, done=0 immediately, independent of clk.
REQ-033 SHALL resume operation on the first rising clk edge after rst returns to 1; a reset asserted mid-count discards all state.

Verification
REQ-034 Defaults, mode 00, up_down=1, en=1, from count=98: counts 99, 100, 0; tc high in the cycle count=0; down from 1: counts 0, 100 with tc pulse.
REQ-035 Mode 01, up: counts 99, 100, 100, 100; tc pulses once only; then up_down=0: counts 99, 98.
REQ-036 Mode 10, up from 95: stops at 100; done=1, tc one pulse; en kept high -> count stays 100; load data_in=8 -> count=8, done=0.
REQ-037 Mode 11, STEP=3, CMAX=10: from 0 counts 3, 6, 9, 10, 7, 4, 1, 0, 3; dir falls at 10 and rises at 0; tc pulses at 10 and at 0.
REQ-038 Load data_in=200 -> count=100; clr and load together -> count=0; load with en=0 -> load takes effect.
REQ-039 rst=0 asynchronously mid-count at 57 -> count=0, dir=1, tc=0, done=0 before the next clk edge; counting resumes after rst=1.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with wrap, saturate, one-shot and ping-pong modes.
// All outputs are registered; step arithmetic is carried one bit wider than the count.
module param_updown_counter #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned CMIN  = 0,
    parameter int unsigned CMAX  = 100,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             up_down,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             done
);

    localparam int unsigned XW = WIDTH + 1;
    localparam logic [XW-1:0] MIN_X      = XW'(CMIN);
    localparam logic [XW-1:0] MAX_X      = XW'(CMAX);
    localparam logic [XW-1:0] STEP_X     = XW'(STEP);
    localparam logic [XW-1:0] MIN_STEP_X = XW'(CMIN + STEP);

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_PING    = 2'b11;

    logic [WIDTH-1:0] count_n;
    logic             dir_n;
    logic             tc_n;
    logic             done_n;

    logic [XW-1:0] count_x;
    logic [XW-1:0] data_x;
    logic [XW-1:0] up_sum;
    logic [XW-1:0] stepped;
    logic [XW-1:0] clamped;
    logic          step_up;
    logic          over;
    logic          under;
    logic          limit;
    logic          wrap_mode;
    logic          ping_mode;
    logic          frozen;
    logic          dir_reload;

    // Step datapath, limit detection and next-state selection.
    always_comb begin
        count_x    = {1'b0, count};
        data_x     = {1'b0, data_in};
        wrap_mode  = (mode == MODE_WRAP);
        ping_mode  = (mode == MODE_PING);
        frozen     = (mode == MODE_ONESHOT) && done;
        step_up    = ping_mode ? dir : up_down;
        dir_reload = ping_mode ? 1'b1 : up_down;
        up_sum     = count_x + STEP_X;
        over       = (up_sum > MAX_X);
        under      = (count_x < MIN_STEP_X);

        if (step_up) begin
            stepped = over ? (wrap_mode ? MIN_X : MAX_X) : up_sum;
        end else begin
            stepped = under ? (wrap_mode ? MAX_X : MIN_X) : (count_x - STEP_X);
        end

        // Saturating modes only flag arrival at the limit, not dwelling on it.
        if (wrap_mode) begin
            limit = step_up ? over : under;
        end else if (step_up) begin
            limit = (stepped == MAX_X) && (count_x != MAX_X);
        end else begin
            limit = (stepped == MIN_X) && (count_x != MIN_X);
        end

        if (data_x < MIN_X) begin
            clamped = MIN_X;
        end else if (data_x > MAX_X) begin
            clamped = MAX_X;
        end else begin
            clamped = data_x;
        end

        count_n = count;
        dir_n   = ping_mode ? dir : up_down;
        tc_n    = 1'b0;
        done_n  = (mode == MODE_ONESHOT) ? done : 1'b0;

        if (clr) begin
            count_n = WIDTH'(MIN_X);
            dir_n   = dir_reload;
            done_n  = 1'b0;
        end else if (load) begin
            count_n = WIDTH'(clamped);
            dir_n   = dir_reload;
            done_n  = 1'b0;
        end else if (en && !frozen) begin
            count_n = WIDTH'(stepped);
            tc_n    = limit;
            if (limit && (mode == MODE_ONESHOT)) begin
                done_n = 1'b1;
            end
            if (limit && ping_mode) begin
                dir_n = ~dir;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= WIDTH'(CMIN);
            dir   <= 1'b1;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= count_n;
            dir   <= dir_n;
            tc    <= tc_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: default-parameter counter driven from a vector table, plus a
// STEP=3/CMAX=10 ping-pong instance and an asynchronous reset sequence.
module tb_param_updown_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, clr, load, up_down;
    logic [1:0]  mode;
    logic [13:0] data_in;

    logic [13:0] count_a, count_b;
    logic        dir_a, tc_a, done_a;
    logic        dir_b, tc_b, done_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    param_updown_counter dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .data_in(data_in), .up_down(up_down), .mode(mode),
        .count(count_a), .dir(dir_a), .tc(tc_a), .done(done_a)
    );

    param_updown_counter #(.WIDTH(14), .CMIN(0), .CMAX(10), .STEP(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .data_in(data_in), .up_down(up_down), .mode(mode),
        .count(count_b), .dir(dir_b), .tc(tc_b), .done(done_b)
    );

    typedef struct {
        logic        clr, load, en, up_down;
        logic [1:0]  mode;
        logic [13:0] data_in;
        logic [13:0] exp_count;
        logic        exp_dir, exp_tc, exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int c, input int l, input int e, input int ud,
                                input int m, input int d, input int ec, input int ed,
                                input int et, input int edn);
        vec_t v;
        v.clr = 1'(c); v.load = 1'(l); v.en = 1'(e); v.up_down = 1'(ud);
        v.mode = 2'(m); v.data_in = 14'(d); v.exp_count = 14'(ec);
        v.exp_dir = 1'(ed); v.exp_tc = 1'(et); v.exp_done = 1'(edn);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic ud,
                         input logic [1:0] m, input logic [13:0] d);
        clr = c; load = l; en = e; up_down = ud; mode = m; data_in = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          b_cnt[9] = '{3, 6, 9, 10, 7, 4, 1, 0, 3};
        int          b_dir[9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        int          b_tc [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};

        // clr, load, en, up_down, mode, data_in -> count, dir, tc, done
        vecs.push_back(mk(0,1,0,1,0, 98,  98,1,0,0));
        vecs.push_back(mk(0,0,1,1,0,  0,  99,1,0,0));
        vecs.push_back(mk(0,0,1,1,0,  0, 100,1,0,0));
        vecs.push_back(mk(0,0,1,1,0,  0,   0,1,1,0));
        vecs.push_back(mk(0,0,1,1,0,  0,   1,1,0,0));
        vecs.push_back(mk(0,0,1,0,0,  0,   0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0,  0, 100,0,1,0));
        vecs.push_back(mk(0,1,1,1,1, 98,  98,1,0,0));
        vecs.push_back(mk(0,0,1,1,1,  0,  99,1,0,0));
        vecs.push_back(mk(0,0,1,1,1,  0, 100,1,1,0));
        vecs.push_back(mk(0,0,1,1,1,  0, 100,1,0,0));
        vecs.push_back(mk(0,0,1,1,1,  0, 100,1,0,0));
        vecs.push_back(mk(0,0,1,0,1,  0,  99,0,0,0));
        vecs.push_back(mk(0,0,1,0,1,  0,  98,0,0,0));
        vecs.push_back(mk(0,1,0,1,2, 95,  95,1,0,0));
        vecs.push_back(mk(0,0,1,1,2,  0,  96,1,0,0));
        vecs.push_back(mk(0,0,1,1,2,  0,  97,1,0,0));
        vecs.push_back(mk(0,0,1,1,2,  0,  98,1,0,0));
        vecs.push_back(mk(0,0,1,1,2,  0,  99,1,0,0));
        vecs.push_back(mk(0,0,1,1,2,  0, 100,1,1,1));
        vecs.push_back(mk(0,0,1,1,2,  0, 100,1,0,1));
        vecs.push_back(mk(0,0,1,1,2,  0, 100,1,0,1));
        vecs.push_back(mk(0,1,1,1,2,  8,   8,1,0,0));
        vecs.push_back(mk(0,1,0,1,0,200, 100,1,0,0));
        vecs.push_back(mk(1,1,1,1,0, 50,   0,1,0,0));
        vecs.push_back(mk(0,0,0,1,0,  0,   0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,  0,   0,0,0,0));
        vecs.push_back(mk(0,1,0,1,2, 99,  99,1,0,0));
        vecs.push_back(mk(0,0,1,1,2,  0, 100,1,1,1));
        vecs.push_back(mk(0,0,0,1,0,  0, 100,1,0,0));

        rst = 1'b0;
        drive(0, 0, 0, 1, 2'b00, 14'd0);
        #12;
        chk("reset.count", int'(count_a), 0);
        chk("reset.dir",   int'(dir_a),   1);
        chk("reset.tc",    int'(tc_a),    0);
        chk("reset.done",  int'(done_a),  0);
        rst = 1'b1;
        #5;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up_down,
                  vecs[i].mode, vecs[i].data_in);
            tick();
            chk($sformatf("v%0d.count", i), int'(count_a), int'(vecs[i].exp_count));
            chk($sformatf("v%0d.dir",   i), int'(dir_a),   int'(vecs[i].exp_dir));
            chk($sformatf("v%0d.tc",    i), int'(tc_a),    int'(vecs[i].exp_tc));
            chk($sformatf("v%0d.done",  i), int'(done_a),  int'(vecs[i].exp_done));
        end

        // Ping-pong with STEP=3, CMAX=10; up_down must be ignored.
        drive(1, 0, 0, 0, 2'b11, 14'd0);
        tick();
        chk("pp.clr.count", int'(count_b), 0);
        chk("pp.clr.dir",   int'(dir_b),   1);
        for (int k = 0; k < 9; k++) begin
            drive(0, 0, 1, 0, 2'b11, 14'd0);
            tick();
            chk($sformatf("pp%0d.count", k), int'(count_b), b_cnt[k]);
            chk($sformatf("pp%0d.dir",   k), int'(dir_b),   b_dir[k]);
            chk($sformatf("pp%0d.tc",    k), int'(tc_b),    b_tc[k]);
        end

        // Asynchronous reset in the middle of a count at 57.
        drive(0, 1, 0, 1, 2'b00, 14'd58);
        tick();
        drive(0, 0, 1, 0, 2'b00, 14'd0);
        tick();
        chk("pre_rst.count", int'(count_a), 57);
        chk("pre_rst.dir",   int'(dir_a),   0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.count", int'(count_a), 0);
        chk("arst.dir",   int'(dir_a),   1);
        chk("arst.tc",    int'(tc_a),    0);
        chk("arst.done",  int'(done_a),  0);
        #1;
        rst = 1'b1;
        drive(0, 0, 1, 1, 2'b00, 14'd0);
        tick();
        chk("resume.count", int'(count_a), 1);
        tick();
        chk("resume2.count", int'(count_a), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
